player_countdown: RTL and testbench

- Per-player countdown timer for the chess clock; one instance per player.
- Counts down minutes:seconds in BCD on the 1 Hz enable while it is that player's turn. Adds a Fischer increment when the player ends a move.
- Drives the OVERFLOW level consumed by the game-end overflow handler (OVERFLOW1/OVERFLOW2 inputs) and the BCD digits shown on the display mux.

---
 rtl/chess_clock_pkg.sv | 32 +++
 rtl/bcd_time_step.sv | 52 +++++
 rtl/player_countdown.sv | 91 +++++++++
 tb/tb_player_countdown.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/chess_clock_pkg.sv
// Shared chess clock types: state encoding, BCD limits
// and a small BCD-pair to binary helper.
package chess_clock_pkg;

  localparam int DW           = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX    = 9;
  localparam int MAX_MIN      = 99;
  localparam int MAX_SEC      = SEC_TENS_MAX * 10 + DIGIT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } state_t;

  typedef struct packed {
    logic [DW-1:0] min_tens;
    logic [DW-1:0] min_ones;
    logic [DW-1:0] sec_tens;
    logic [DW-1:0] sec_ones;
  } bcd_time_t;

  function automatic logic [6:0] bcd_val(
    input logic [DW-1:0] tens,
    input logic [DW-1:0] ones
  );
    return 7'(tens * 10 + ones);
  endfunction

endpackage

// File: rtl/bcd_time_step.sv
// Combinational mm:ss adjust: optional bonus add and one
// second decrement in a single step, with carry/borrow/saturation.
module bcd_time_step
  import chess_clock_pkg::*;
(
  input  bcd_time_t  cur,
  input  logic       add_en,
  input  logic       dec_en,
  input  logic [5:0] bonus,
  output bcd_time_t  nxt,
  output logic       is_zero
);

  logic [6:0] m;
  logic [6:0] s;
  logic [6:0] s_sum;
  logic [7:0] m_new;
  logic       carry;
  logic       borrow;

  always_comb begin
    m      = bcd_val(cur.min_tens, cur.min_ones);
    s      = bcd_val(cur.sec_tens, cur.sec_ones);
    s_sum  = s + (add_en ? 7'(bonus) : 7'd0);
    carry  = 1'b0;
    borrow = 1'b0;
    // never count below 00:00
    if (dec_en && (m != 7'd0 || s_sum != 7'd0)) begin
      if (s_sum == 7'd0) begin
        s_sum  = 7'(MAX_SEC);
        borrow = 1'b1;
      end else begin
        s_sum = s_sum - 7'd1;
      end
    end
    if (s_sum > 7'(MAX_SEC)) begin
      s_sum = s_sum - 7'd60;
      carry = 1'b1;
    end
    m_new = {1'b0, m} + 8'(carry) - 8'(borrow);
    if (m_new > 8'(MAX_MIN)) begin
      m_new = 8'(MAX_MIN);
      s_sum = 7'(MAX_SEC);
    end
    nxt.min_tens = DW'(m_new / 8'd10);
    nxt.min_ones = DW'(m_new % 8'd10);
    nxt.sec_tens = DW'(s_sum / 7'd10);
    nxt.sec_ones = DW'(s_sum % 7'd10);
    is_zero = (m_new == 8'd0) && (s_sum == 7'd0);
  end

endmodule

// File: rtl/player_countdown.sv
// Per-player BCD countdown with Fischer bonus and
// registered overflow level for the game-end logic.
module player_countdown
  import chess_clock_pkg::*;
#(
  parameter int INIT_MIN  = 5,
  parameter int INIT_SEC  = 0,
  parameter int BONUS_SEC = 0
)(
  input  logic          CLK,
  input  logic          CLR_N,
  input  logic          CE,
  input  logic          RUN,
  input  logic          LOAD,
  input  logic          ADD_BONUS,
  output logic [DW-1:0] MIN_TENS,
  output logic [DW-1:0] MIN_ONES,
  output logic [DW-1:0] SEC_TENS,
  output logic [DW-1:0] SEC_ONES,
  output logic [1:0]    STATE,
  output logic          OVERFLOW
);

  localparam bcd_time_t INIT_T = {
    4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
    4'(INIT_SEC / 10), 4'(INIT_SEC % 10)
  };

  state_t    state_q, state_n;
  bcd_time_t time_q, time_n, step_t;
  logic      ovf_q, ovf_n;
  logic      add_en, dec_en, step_zero;

  assign add_en = !LOAD && ADD_BONUS &&
                  (state_q == ST_RUNNING ||
                   state_q == ST_PAUSED);
  assign dec_en = !LOAD && CE &&
                  (state_q == ST_RUNNING);

  bcd_time_step u_step (
    .cur     (time_q),
    .add_en  (add_en),
    .dec_en  (dec_en),
    .bonus   (6'(BONUS_SEC)),
    .nxt     (step_t),
    .is_zero (step_zero)
  );

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_IDLE;
      time_q  <= INIT_T;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      time_q  <= time_n;
      ovf_q   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state_q;
    if (LOAD) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (RUN) state_n = ST_RUNNING;
        ST_RUNNING: begin
          // zero time expires even without a tick
          if (step_zero)   state_n = ST_EXPIRED;
          else if (!RUN)   state_n = ST_PAUSED;
        end
        ST_PAUSED:  if (RUN) state_n = ST_RUNNING;
        ST_EXPIRED: state_n = ST_EXPIRED;
      endcase
    end
  end

  always_comb begin
    time_n = LOAD ? INIT_T : step_t;
    ovf_n  = (state_n == ST_EXPIRED);
  end

  assign MIN_TENS = time_q.min_tens;
  assign MIN_ONES = time_q.min_ones;
  assign SEC_TENS = time_q.sec_tens;
  assign SEC_ONES = time_q.sec_ones;
  assign STATE    = state_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_player_countdown.sv
// Bench for player_countdown: four parameterisations driven
// together, checked against a seconds-based reference model.
module tb_player_countdown;

  localparam int N = 4;

  logic CLK = 1'b0;
  logic CLR_N = 1'b1;
  logic CE = 1'b0;
  logic RUN = 1'b0;
  logic LOAD = 1'b0;
  logic ADD_BONUS = 1'b0;

  always #5 CLK = ~CLK;

  logic [3:0] mt[N], mo[N], sct[N], so[N];
  logic [1:0] stv[N];
  logic       ov[N];

  int im[N] = '{1, 99, 10, 0};
  int is[N] = '{0, 58, 0, 0};
  int bs[N] = '{5, 5, 0, 0};

  int t[N];
  int st[N];
  int nchk = 0;
  int npass = 0;

  player_countdown #(
    .INIT_MIN(1), .INIT_SEC(0), .BONUS_SEC(5)
  ) u0 (
    .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .RUN(RUN),
    .LOAD(LOAD), .ADD_BONUS(ADD_BONUS),
    .MIN_TENS(mt[0]), .MIN_ONES(mo[0]),
    .SEC_TENS(sct[0]), .SEC_ONES(so[0]),
    .STATE(stv[0]), .OVERFLOW(ov[0])
  );

  player_countdown #(
    .INIT_MIN(99), .INIT_SEC(58), .BONUS_SEC(5)
  ) u1 (
    .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .RUN(RUN),
    .LOAD(LOAD), .ADD_BONUS(ADD_BONUS),
    .MIN_TENS(mt[1]), .MIN_ONES(mo[1]),
    .SEC_TENS(sct[1]), .SEC_ONES(so[1]),
    .STATE(stv[1]), .OVERFLOW(ov[1])
  );

  player_countdown #(
    .INIT_MIN(10), .INIT_SEC(0), .BONUS_SEC(0)
  ) u2 (
    .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .RUN(RUN),
    .LOAD(LOAD), .ADD_BONUS(ADD_BONUS),
    .MIN_TENS(mt[2]), .MIN_ONES(mo[2]),
    .SEC_TENS(sct[2]), .SEC_ONES(so[2]),
    .STATE(stv[2]), .OVERFLOW(ov[2])
  );

  player_countdown #(
    .INIT_MIN(0), .INIT_SEC(0), .BONUS_SEC(0)
  ) u3 (
    .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .RUN(RUN),
    .LOAD(LOAD), .ADD_BONUS(ADD_BONUS),
    .MIN_TENS(mt[3]), .MIN_ONES(mo[3]),
    .SEC_TENS(sct[3]), .SEC_ONES(so[3]),
    .STATE(stv[3]), .OVERFLOW(ov[3])
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return ((m / 10) << 12) | ((m % 10) << 8) |
           ((s / 10) << 4) | (s % 10);
  endfunction

  function automatic logic [31:0] shown(input int i);
    return 32'({mt[i], mo[i], sct[i], so[i]});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      t[i]  = im[i] * 60 + is[i];
      st[i] = 0;
    end
  endtask

  // 0 idle, 1 running, 2 paused, 3 expired; time in seconds
  task automatic model_edge(
    input bit c, input bit r, input bit l, input bit a
  );
    for (int i = 0; i < N; i++) begin
      int n;
      n = t[i];
      if (l) begin
        t[i]  = im[i] * 60 + is[i];
        st[i] = 0;
      end else begin
        case (st[i])
          0: if (r) st[i] = 1;
          1: begin
            if (a) n = n + bs[i];
            if (c && n > 0) n = n - 1;
            if (n > 5999) n = 5999;
            t[i] = n;
            if (n == 0) st[i] = 3;
            else if (!r) st[i] = 2;
          end
          2: begin
            if (a) n = n + bs[i];
            if (n > 5999) n = 5999;
            t[i] = n;
            if (r) st[i] = 1;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("time%0d", i), shown(i), to_bcd(t[i]));
      check($sformatf("state%0d", i),
            32'(stv[i]), 32'(st[i]));
      check($sformatf("ovf%0d", i),
            32'(ov[i]), 32'(st[i] == 3));
    end
  endtask

  task automatic cycle(
    input bit c, input bit r, input bit l, input bit a
  );
    CE = c;
    RUN = r;
    LOAD = l;
    ADD_BONUS = a;
    @(posedge CLK);
    model_edge(c, r, l, a);
    #1;
    check_all();
  endtask

  initial begin
    bit c, r, l, a;
    model_reset();
    #1 CLR_N = 1'b0;
    #2 check_all();
    @(negedge CLK);
    CLR_N = 1'b1;

    repeat (4) cycle(1'($urandom_range(0, 1)), 0, 0, 0);
    cycle(1, 1, 0, 0);
    repeat (60) cycle(1, 1, 0, 0);
    check("u0_expired_time", shown(0), 32'h0);
    check("u0_expired_ovf", 32'(ov[0]), 32'd1);
    check("u0_expired_state", 32'(stv[0]), 32'd3);

    repeat (5) cycle(1, 0, 0, 0);
    check("u1_paused", 32'(stv[1]), 32'd2);

    cycle(0, 0, 1, 0);
    check("u0_load_state", 32'(stv[0]), 32'd0);
    check("u0_load_ovf", 32'(ov[0]), 32'd0);

    cycle(0, 1, 0, 0);
    repeat (3) cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check("u0_bonus_carry", shown(0), 32'h0102);
    check("u1_bonus_sat", shown(1), 32'h9959);

    cycle(0, 1, 0, 0);
    repeat (61) cycle(1, 1, 0, 0);
    check("u0_at_one", shown(0), 32'h0001);
    cycle(1, 1, 0, 1);
    check("u0_bonus_dec", shown(0), 32'h0005);
    check("u0_no_expiry", 32'(stv[0]), 32'd1);

    repeat (5) cycle(1, 1, 0, 0);
    repeat (10) cycle(1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 0,
                      1'($urandom_range(0, 1)));
    check("u0_hold_time", shown(0), 32'h0);
    check("u0_hold_ovf", 32'(ov[0]), 32'd1);

    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    repeat (20) cycle(1, 1, 0, 0);
    #2 CLR_N = 1'b0;
    #1 model_reset();
    check_all();
    check("u0_async_init", shown(0), 32'h0100);
    #2 CLR_N = 1'b1;
    repeat (3) cycle(1, 0, 0, 0);

    r = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) r = ~r;
      c = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 99) == 0);
      a = ($urandom_range(0, 7) == 0);
      cycle(c, r, l, a);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
